// File: rtl/fetch_controller.sv
// rtl/fetch_controller.sv - instruction fetch FSM with stall, branch redirect and halt detection
module fetch_controller #(
    parameter int         MEM_DEPTH = 100,
    parameter logic [5:0] HALT_OP   = 6'b111111
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic [31:0] instr_in,
    output logic [31:0] imem_addr,
    output logic [31:0] instr_out,
    output logic        instr_valid,
    output logic [31:0] pc_out,
    output logic        halted,
    output logic        fault
);

    typedef enum logic [1:0] {IDLE, RUN, BUBBLE, HALT} state_t;

    localparam logic [31:0] LAST_ADDR = 32'(MEM_DEPTH - 1);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_out_q, instr_out_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic        instr_valid_q, instr_valid_d;
    logic        fault_q, fault_d;

    logic        last_word;
    logic        fetch_final;
    logic        do_fetch;
    logic        do_redirect;

    // The word on the output is the final one: halt opcode or top of memory.
    assign last_word   = instr_valid_q &&
                         ((instr_out_q[31:26] == HALT_OP) || (pc_out_q == LAST_ADDR));
    assign fetch_final = (instr_in[31:26] == HALT_OP) || (pc_q == LAST_ADDR);

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_out_d   = instr_out_q;
        pc_out_d      = pc_out_q;
        instr_valid_d = instr_valid_q;
        fault_d       = fault_q;
        do_fetch      = 1'b0;
        do_redirect   = 1'b0;

        case (state_q)
            IDLE: begin
                instr_valid_d = 1'b0;
                if (start) begin
                    pc_d    = 32'd0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (last_word) begin
                    if (!stall) begin
                        state_d       = HALT;
                        instr_valid_d = 1'b0;
                    end
                end else if (branch_taken) begin
                    do_redirect = 1'b1;
                end else if (!stall) begin
                    do_fetch = 1'b1;
                end
            end
            BUBBLE: begin
                // Output register is empty here, so refill it even under stall.
                if (branch_taken) begin
                    do_redirect = 1'b1;
                end else begin
                    do_fetch = 1'b1;
                end
            end
            HALT: begin
                instr_valid_d = 1'b0;
            end
            default: begin
                state_d       = IDLE;
                instr_valid_d = 1'b0;
            end
        endcase

        if (do_redirect) begin
            instr_valid_d = 1'b0;
            if (branch_target > LAST_ADDR) begin
                state_d = HALT;
                fault_d = 1'b1;
            end else begin
                pc_d    = branch_target;
                state_d = BUBBLE;
            end
        end

        if (do_fetch) begin
            instr_out_d   = instr_in;
            pc_out_d      = pc_q;
            instr_valid_d = 1'b1;
            state_d       = RUN;
            if (!fetch_final) begin
                pc_d = pc_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            pc_q          <= 32'd0;
            instr_out_q   <= 32'd0;
            pc_out_q      <= 32'd0;
            instr_valid_q <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_out_q   <= instr_out_d;
            pc_out_q      <= pc_out_d;
            instr_valid_q <= instr_valid_d;
            fault_q       <= fault_d;
        end
    end

    assign imem_addr   = pc_q;
    assign instr_out   = instr_out_q;
    assign pc_out      = pc_out_q;
    assign instr_valid = instr_valid_q;
    assign halted      = (state_q == HALT);
    assign fault       = fault_q;

endmodule

// File: tb/tb_fetch_controller.sv
// tb/tb_fetch_controller.sv - scoreboard bench for fetch_controller
module tb_fetch_controller;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } word_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'd0;
    logic [31:0] instr_in;
    logic [31:0] imem_addr;
    logic [31:0] instr_out;
    logic        instr_valid;
    logic [31:0] pc_out;
    logic        halted;
    logic        fault;

    logic [31:0] mem [0:99];
    word_t       exp_q [$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] max_addr = 32'd0;

    fetch_controller #(.MEM_DEPTH(100), .HALT_OP(6'b111111)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .instr_in      (instr_in),
        .imem_addr     (imem_addr),
        .instr_out     (instr_out),
        .instr_valid   (instr_valid),
        .pc_out        (pc_out),
        .halted        (halted),
        .fault         (fault)
    );

    always #5 clk = ~clk;

    always_comb begin
        instr_in = 32'hDEAD_BEEF;
        if (imem_addr < 32'd100) instr_in = mem[imem_addr[6:0]];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word_at(input int i);
        return 32'h0100_0000 + 32'(i) * 32'h0000_0101;
    endfunction

    task automatic push(input int a);
        word_t w;
        w.pc    = 32'(a);
        w.instr = mem[a];
        exp_q.push_back(w);
    endtask

    // A word is consumed by decode on each edge where it is valid and not stalled.
    always @(negedge clk) begin
        if (!rst) begin
            if (imem_addr > max_addr) max_addr = imem_addr;
            if (instr_valid && !stall) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_pc", pc_out, 32'hFFFF_FFFF);
                end else begin
                    word_t w;
                    w = exp_q.pop_front();
                    check("sb_pc", pc_out, w.pc);
                    check("sb_instr", instr_out, w.instr);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        start = 1'b0;
        stall = 1'b0;
        branch_taken = 1'b0;
        branch_target = 32'd0;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic do_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic drain(input string tag);
        check(tag, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        bit found;
        for (int i = 0; i < 100; i++) mem[i] = word_at(i);

        // Reset state
        do_reset();
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_fault", {31'd0, fault}, 32'd0);
        check("rst_pc_out", pc_out, 32'd0);
        check("rst_instr_out", instr_out, 32'd0);
        check("rst_imem_addr", imem_addr, 32'd0);

        // Straight-line fetch with a three-cycle stall on pc_out=1
        for (int i = 0; i < 4; i++) push(i);
        do_start();
        check("start_c1_valid", {31'd0, instr_valid}, 32'd0);
        tick();
        check("start_c2_valid", {31'd0, instr_valid}, 32'd1);
        check("start_c2_pc", pc_out, 32'd0);
        tick();
        check("pre_stall_pc", pc_out, 32'd1);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_pc_hold", pc_out, 32'd1);
            check("stall_instr_hold", instr_out, mem[1]);
            check("stall_valid_hold", {31'd0, instr_valid}, 32'd1);
        end
        stall = 1'b0;
        tick();
        check("post_stall_pc", pc_out, 32'd2);
        tick();
        check("run_pc3", pc_out, 32'd3);
        tick();
        drain("drain_run");
        do_reset();

        // Branch to 10 with stall also asserted
        push(0); push(10); push(11);
        do_start();
        tick();
        tick();
        check("br_pre_addr", imem_addr, 32'd2);
        stall = 1'b1;
        branch_taken = 1'b1;
        branch_target = 32'd10;
        tick();
        stall = 1'b0;
        branch_taken = 1'b0;
        check("br_bubble_valid", {31'd0, instr_valid}, 32'd0);
        check("br_bubble_addr", imem_addr, 32'd10);
        tick();
        check("br_target_valid", {31'd0, instr_valid}, 32'd1);
        check("br_target_pc", pc_out, 32'd10);
        check("br_target_instr", instr_out, mem[10]);
        tick();
        tick();
        drain("drain_branch");
        do_reset();

        // Halt opcode at address 5
        mem[5] = 32'hFC00_0005;
        for (int i = 0; i < 6; i++) push(i);
        do_start();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (instr_valid && pc_out == 32'd5) found = 1'b1;
        end
        check("halt_word_seen", {31'd0, found}, 32'd1);
        check("halt_word_not_halted", {31'd0, halted}, 32'd0);
        tick();
        check("halt_halted", {31'd0, halted}, 32'd1);
        check("halt_fault", {31'd0, fault}, 32'd0);
        check("halt_valid", {31'd0, instr_valid}, 32'd0);
        start = 1'b1;
        branch_taken = 1'b1;
        branch_target = 32'd2;
        tick();
        start = 1'b0;
        branch_taken = 1'b0;
        tick();
        check("halt_sticky", {31'd0, halted}, 32'd1);
        check("halt_sticky_valid", {31'd0, instr_valid}, 32'd0);
        check("halt_addr_held", imem_addr, 32'd5);
        drain("drain_halt");
        mem[5] = word_at(5);
        do_reset();

        // Out-of-range branch target faults, reset clears it
        push(0); push(1);
        do_start();
        tick();
        tick();
        check("fault_pre_pc", pc_out, 32'd1);
        branch_taken = 1'b1;
        branch_target = 32'd100;
        tick();
        branch_taken = 1'b0;
        check("fault_halted", {31'd0, halted}, 32'd1);
        check("fault_flag", {31'd0, fault}, 32'd1);
        check("fault_valid", {31'd0, instr_valid}, 32'd0);
        tick();
        check("fault_hold", {31'd0, fault}, 32'd1);
        drain("drain_fault");
        rst = 1'b1;
        start = 1'b1;
        stall = 1'b1;
        branch_taken = 1'b1;
        branch_target = 32'd5;
        tick();
        check("rst_ovr_halted", {31'd0, halted}, 32'd0);
        check("rst_ovr_fault", {31'd0, fault}, 32'd0);
        check("rst_ovr_pc_out", pc_out, 32'd0);
        check("rst_ovr_instr", instr_out, 32'd0);
        check("rst_ovr_addr", imem_addr, 32'd0);
        rst = 1'b0;
        start = 1'b0;
        stall = 1'b0;
        branch_taken = 1'b0;
        tick();
        check("rst_ovr_idle_valid", {31'd0, instr_valid}, 32'd0);
        push(0); push(1);
        do_start();
        tick();
        check("refetch_pc0", pc_out, 32'd0);
        tick();
        tick();
        drain("drain_refetch");
        do_reset();

        // Run to the end of memory
        for (int i = 0; i < 100; i++) push(i);
        max_addr = 32'd0;
        do_start();
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            tick();
            if (halted) found = 1'b1;
        end
        check("end_halted", {31'd0, found}, 32'd1);
        check("end_fault", {31'd0, fault}, 32'd0);
        check("end_valid", {31'd0, instr_valid}, 32'd0);
        check("end_pc_out", pc_out, 32'd99);
        check("end_max_addr", max_addr, 32'd99);
        drain("drain_end");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 The block SHALL provide parameter MEM_DEPTH, default 100, giving the number of instruction words in the instruction memory.
REQ-002 The block SHALL provide parameter HALT_OP, default 6'b111111, giving the opcode (bits [31:26]) that stops fetching.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse that begins fetching from address 0 when IDLE.
REQ-006 stall  input  1  decode back-pressure; hold current output and PC.
REQ-007 branch_taken  input  1  redirect request from execute.
REQ-008 branch_target  input  32  word address to redirect to.
REQ-009 instr_in  input  32  combinational read data from instruction memory at imem_addr.
REQ-010 imem_addr  output  32  word address driven to instruction memory.
REQ-011 instr_out  output  32  registered instruction to decode.
REQ-012 instr_valid  output  1  instr_out holds a real instruction this cycle.
REQ-013 pc_out  output  32  address instr_out was fetched from.
REQ-014 halted  output  1  fetch stopped (halt opcode, end of memory or fault).
REQ-015 fault  output  1  halt was caused by an out-of-range branch target.

Function
REQ-016 The FSM SHALL have states IDLE, RUN, BUBBLE and HALT.
REQ-017 imem_addr SHALL equal the internal PC register in every state; the memory read is combinational, same cycle.
REQ-018 IDLE: instr_valid=0; on start, PC<=0 and next state RUN; start is ignored in all other states.
REQ-019 RUN, no stall, no branch: instr_out<=instr_in, pc_out<=PC, instr_valid<=1, PC<=PC+1.
REQ-020 RUN with stall=1 and branch_taken=0: PC, instr_out, pc_out and instr_valid SHALL hold their values.
REQ-021 RUN with branch_taken=1, whatever stall is: PC<=branch_target, instr_valid<=0, next state BUBBLE; the fetched word is discarded.
REQ-022 BUBBLE SHALL last exactly one cycle with instr_valid=0, then return to RUN; a branch_taken in BUBBLE re-targets PC and stays in BUBBLE one more cycle.
REQ-023 Priority SHALL be rst > branch_taken > stall > normal fetch.
REQ-024 A branch_target >= MEM_DEPTH SHALL cause next state HALT with fault<=1 and instr_valid<=0.
REQ-025 When RUN would fetch (no stall, no branch) and instr_in[31:26]==HALT_OP, the block SHALL deliver the halt word with instr_valid<=1 for one cycle and then enter HALT.
REQ-026 When RUN would fetch with PC==MEM_DEPTH-1 (a non-halt word), that word SHALL be delivered and the next state SHALL be HALT; PC never advances past MEM_DEPTH-1.
REQ-027 In HALT: halted=1, instr_valid=0, PC held; start, stall and branch_taken ignored; only rst exits HALT.
REQ-028 halted SHALL be 1 only in HALT; fault SHALL hold until reset.
REQ-029 PC arithmetic SHALL be unsigned 32-bit; it cannot wrap because of REQ-026.

Reset
REQ-030 rst=1 at a clock edge SHALL force IDLE, PC=0, instr_out=0, pc_out=0, instr_valid=0, halted=0, fault=0, in any state including mid-BUBBLE and mid-stall.
REQ-031 rst SHALL override start, stall and branch_taken asserted in the same cycle.

Verification
REQ-032 Reset, start at cycle 1, mem[0..3]=A,B,C,D, no stall -> instr_valid=1 from cycle 2; (pc_out, instr_out) = (0,A), (1,B), (2,C), (3,D) on consecutive cycles.
REQ-033 stall=1 for 3 cycles while pc_out=1 -> instr_out=B and pc_out=1 held 3 cycles, then (2,C) follows with no word skipped or repeated.
REQ-034 branch_taken=1, target=10, while fetching PC=2 (stall also 1) -> one cycle instr_valid=0, then pc_out=10 with instr_out=mem[10].
REQ-035 Opcode 6'b111111 placed at mem[5] -> word at pc_out=5 delivered valid, next cycle halted=1, fault=0, instr_valid=0; later start and branch ignored.
REQ-036 Branch target 100 with MEM_DEPTH=100 -> halted=1 and fault=1 next cycle, no valid output; rst then clears both, and start refetches from 0.
REQ-037 Run with no halt word to PC=99 -> word 99 delivered, then halted=1; imem_addr never exceeds 99.
